// File: rtl/tpm_request_frontend.sv
// tpm_request_frontend: upstream request stage of the triple-ported memory.
// Each of the three clients feeds its own DEPTH-entry FIFO. The head entry of
// each FIFO drives the matching memory port, and is retired only on an edge
// where the memory captures it (freeze_inputs low).
// Optional build macro: TPM_FRONTEND_STATS_EN adds per-port saturating
// issue/stall counters and a stats_clear input.
module tpm_request_frontend #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              c1_req_valid,
    output logic              c1_req_ready,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_data,
    input  logic              c1_wen,
    input  logic              c2_req_valid,
    output logic              c2_req_ready,
    input  logic [ADDR_W-1:0] c2_addr,
    input  logic [DATA_W-1:0] c2_data,
    input  logic              c2_wen,
    input  logic              c3_req_valid,
    output logic              c3_req_ready,
    input  logic [ADDR_W-1:0] c3_addr,
    input  logic [DATA_W-1:0] c3_data,
    input  logic              c3_wen,
    output logic [ADDR_W-1:0] port1_addr,
    output logic [DATA_W-1:0] port1_data_in,
    output logic              port1_wen,
    output logic              port1_valid_in,
    output logic [ADDR_W-1:0] port2_addr,
    output logic [DATA_W-1:0] port2_data_in,
    output logic              port2_wen,
    output logic              port2_valid_in,
    output logic [ADDR_W-1:0] port3_addr,
    output logic [DATA_W-1:0] port3_data_in,
    output logic              port3_wen,
    output logic              port3_valid_in,
    input  logic              freeze_inputs,
    input  logic              flush
`ifdef TPM_FRONTEND_STATS_EN
    ,
    input  logic              stats_clear,
    output logic [15:0]       stat1_issued,
    output logic [15:0]       stat2_issued,
    output logic [15:0]       stat3_issued,
    output logic [15:0]       stat1_stall,
    output logic [15:0]       stat2_stall,
    output logic [15:0]       stat3_stall
`endif
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [2:0]         req_valid;
    logic [2:0]         req_ready;
    logic [2:0]         head_valid;
    logic [2:0]         push;
    logic [2:0]         pop;
    logic [ENTRY_W-1:0] req_entry  [3];
    logic [ENTRY_W-1:0] head_entry [3];
    logic               ready_en;

    assign req_valid    = {c3_req_valid, c2_req_valid, c1_req_valid};
    assign req_entry[0] = {c1_addr, c1_data, c1_wen};
    assign req_entry[1] = {c2_addr, c2_data, c2_wen};
    assign req_entry[2] = {c3_addr, c3_data, c3_wen};

    // Holds ready low during reset and for the edge of release, so clients see
    // ready only from the first full cycle after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    for (genvar p = 0; p < 3; p++) begin : g_port
        logic [ENTRY_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]   wr_ptr;
        logic [PTR_W-1:0]   rd_ptr;
        logic [CNT_W-1:0]   count;

        // Ready comes only from registered state; a pop on a full FIFO does
        // not open a slot until the following cycle.
        assign req_ready[p]  = ready_en & (count != FULL_CNT);
        assign head_valid[p] = (count != '0);
        assign push[p]       = req_valid[p] & req_ready[p];
        assign pop[p]        = head_valid[p] & ~freeze_inputs;
        assign head_entry[p] = head_valid[p] ? mem[rd_ptr] : '0;

        // Pointer and occupancy tracking; flush wins over any push or pop.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[p]) wr_ptr <= wr_ptr + 1'b1;
                if (pop[p])  rd_ptr <= rd_ptr + 1'b1;
                case ({push[p], pop[p]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        // Entry storage; contents are only visible through a non-empty head.
        always_ff @(posedge clk) begin
            if (push[p] && !flush) mem[wr_ptr] <= req_entry[p];
        end
    end

    assign c1_req_ready   = req_ready[0];
    assign c2_req_ready   = req_ready[1];
    assign c3_req_ready   = req_ready[2];
    assign port1_valid_in = head_valid[0];
    assign port2_valid_in = head_valid[1];
    assign port3_valid_in = head_valid[2];
    assign port1_addr     = head_entry[0][ENTRY_W-1 -: ADDR_W];
    assign port2_addr     = head_entry[1][ENTRY_W-1 -: ADDR_W];
    assign port3_addr     = head_entry[2][ENTRY_W-1 -: ADDR_W];
    assign port1_data_in  = head_entry[0][DATA_W:1];
    assign port2_data_in  = head_entry[1][DATA_W:1];
    assign port3_data_in  = head_entry[2][DATA_W:1];
    assign port1_wen      = head_entry[0][0];
    assign port2_wen      = head_entry[1][0];
    assign port3_wen      = head_entry[2][0];

`ifdef TPM_FRONTEND_STATS_EN
    logic [15:0] stat_issued [3];
    logic [15:0] stat_stall  [3];

    for (genvar s = 0; s < 3; s++) begin : g_stats
        // Saturating counters of retired entries and of frozen cycles with a
        // valid head; stats_clear beats any increment.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stat_issued[s] <= '0;
                stat_stall[s]  <= '0;
            end else if (stats_clear) begin
                stat_issued[s] <= '0;
                stat_stall[s]  <= '0;
            end else begin
                if (pop[s] && stat_issued[s] != 16'hFFFF)
                    stat_issued[s] <= stat_issued[s] + 16'd1;
                if (head_valid[s] && freeze_inputs && stat_stall[s] != 16'hFFFF)
                    stat_stall[s] <= stat_stall[s] + 16'd1;
            end
        end
    end

    assign stat1_issued = stat_issued[0];
    assign stat2_issued = stat_issued[1];
    assign stat3_issued = stat_issued[2];
    assign stat1_stall  = stat_stall[0];
    assign stat2_stall  = stat_stall[1];
    assign stat3_stall  = stat_stall[2];
`endif

endmodule

// File: tb/tb_tpm_request_frontend.sv
// Testbench for tpm_request_frontend: directed scenarios plus a randomized
// phase, all compared against a queue-based model of the three request FIFOs.
// Build with TPM_FRONTEND_STATS_EN defined to also exercise the counters.
module tb_tpm_request_frontend;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef logic [ADDR_W+DATA_W:0] entry_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [2:0]        req_valid;
    logic [ADDR_W-1:0] req_addr [3];
    logic [DATA_W-1:0] req_data [3];
    logic [2:0]        req_wen;
    logic              freeze_inputs;
    logic              flush;

    wire  [2:0]        req_ready;
    wire  [2:0]        port_valid;
    wire  [2:0]        port_wen;
    wire  [ADDR_W-1:0] port_addr [3];
    wire  [DATA_W-1:0] port_data [3];

`ifdef TPM_FRONTEND_STATS_EN
    logic              stats_clear;
    wire  [15:0]       stat_issued [3];
    wire  [15:0]       stat_stall  [3];
    int                model_issued [3];
    int                model_stall  [3];
`endif

    entry_t mq [3][$];
    logic   model_ready_en;
    int     checks = 0;
    int     errors = 0;

    tpm_request_frontend #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .c1_req_valid(req_valid[0]), .c1_req_ready(req_ready[0]),
        .c1_addr(req_addr[0]), .c1_data(req_data[0]), .c1_wen(req_wen[0]),
        .c2_req_valid(req_valid[1]), .c2_req_ready(req_ready[1]),
        .c2_addr(req_addr[1]), .c2_data(req_data[1]), .c2_wen(req_wen[1]),
        .c3_req_valid(req_valid[2]), .c3_req_ready(req_ready[2]),
        .c3_addr(req_addr[2]), .c3_data(req_data[2]), .c3_wen(req_wen[2]),
        .port1_addr(port_addr[0]), .port1_data_in(port_data[0]),
        .port1_wen(port_wen[0]), .port1_valid_in(port_valid[0]),
        .port2_addr(port_addr[1]), .port2_data_in(port_data[1]),
        .port2_wen(port_wen[1]), .port2_valid_in(port_valid[1]),
        .port3_addr(port_addr[2]), .port3_data_in(port_data[2]),
        .port3_wen(port_wen[2]), .port3_valid_in(port_valid[2]),
        .freeze_inputs(freeze_inputs), .flush(flush)
`ifdef TPM_FRONTEND_STATS_EN
        ,
        .stats_clear(stats_clear),
        .stat1_issued(stat_issued[0]), .stat2_issued(stat_issued[1]),
        .stat3_issued(stat_issued[2]),
        .stat1_stall(stat_stall[0]), .stat2_stall(stat_stall[1]),
        .stat3_stall(stat_stall[2])
`endif
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int p, input logic v, input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] d, input logic w);
        req_valid[p] = v;
        req_addr[p]  = a;
        req_data[p]  = d;
        req_wen[p]   = w;
    endtask

    function automatic logic model_ready(input int p);
        return reset_n && model_ready_en && (mq[p].size() < DEPTH);
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 3; p++) begin
            mq[p].delete();
`ifdef TPM_FRONTEND_STATS_EN
            model_issued[p] = 0;
            model_stall[p]  = 0;
`endif
        end
        model_ready_en = 1'b0;
    endtask

    // One clock edge of the reference: decisions use pre-edge occupancy
    task automatic model_edge();
        logic do_push [3];
        logic do_pop  [3];
        if (!reset_n) return;
        for (int p = 0; p < 3; p++) begin
            do_push[p] = req_valid[p] && model_ready(p);
            do_pop[p]  = (mq[p].size() > 0) && !freeze_inputs;
`ifdef TPM_FRONTEND_STATS_EN
            if (stats_clear) begin
                model_issued[p] = 0;
                model_stall[p]  = 0;
            end else begin
                if (do_pop[p] && model_issued[p] < 65535) model_issued[p]++;
                if (mq[p].size() > 0 && freeze_inputs && model_stall[p] < 65535) model_stall[p]++;
            end
`endif
        end
        for (int p = 0; p < 3; p++) begin
            if (flush) mq[p].delete();
            else begin
                if (do_pop[p])  void'(mq[p].pop_front());
                if (do_push[p]) mq[p].push_back({req_addr[p], req_data[p], req_wen[p]});
            end
        end
        model_ready_en = 1'b1;
    endtask

    task automatic checkOutput();
        entry_t head;
        for (int p = 0; p < 3; p++) begin
            head = (mq[p].size() > 0) ? mq[p][0] : '0;
            chk($sformatf("ready%0d", p + 1), 32'(req_ready[p]), 32'(model_ready(p)));
            chk($sformatf("valid%0d", p + 1), 32'(port_valid[p]), 32'(mq[p].size() > 0));
            chk($sformatf("addr%0d", p + 1), 32'(port_addr[p]), 32'(head[ADDR_W+DATA_W -: ADDR_W]));
            chk($sformatf("data%0d", p + 1), 32'(port_data[p]), 32'(head[DATA_W:1]));
            chk($sformatf("wen%0d", p + 1), 32'(port_wen[p]), 32'(head[0]));
`ifdef TPM_FRONTEND_STATS_EN
            chk($sformatf("issued%0d", p + 1), 32'(stat_issued[p]), 32'(model_issued[p]));
            chk($sformatf("stall%0d", p + 1), 32'(stat_stall[p]), 32'(model_stall[p]));
`endif
        end
    endtask

    // Advance one clock: update the model at the edge, compare at the falling edge
    task automatic step_cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle_inputs();
        for (int p = 0; p < 3; p++) applyStimulus(p, 1'b0, '0, '0, 1'b0);
        freeze_inputs = 1'b0;
        flush         = 1'b0;
`ifdef TPM_FRONTEND_STATS_EN
        stats_clear   = 1'b0;
`endif
    endtask

    initial begin
        int sent [3];
        int seen [3];
        logic acc [3];

        // ---- Reset and idle ----
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) step_cycle();
        chk("reset_ready1", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 checkOutput();
        step_cycle();
        chk("post_reset_ready3", 32'(req_ready[2]), 32'd1);
        chk("post_reset_valid2", 32'(port_valid[1]), 32'd0);

        // ---- Single push on client 1, no freeze ----
        applyStimulus(0, 1'b1, 12'h123, 16'hBEEF, 1'b1);
        step_cycle();
        applyStimulus(0, 1'b0, '0, '0, 1'b0);
        chk("single_valid", 32'(port_valid[0]), 32'd1);
        chk("single_addr", 32'(port_addr[0]), 32'h123);
        chk("single_data", 32'(port_data[0]), 32'hBEEF);
        step_cycle();
        chk("single_popped", 32'(port_valid[0]), 32'd0);

        // ---- Freeze for 6 cycles while client 2 offers 5 requests ----
        freeze_inputs = 1'b1;
        sent[1] = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1, sent[1] < 5, 12'(12'h200 + sent[1]), 16'(16'hA000 + sent[1]), sent[1][0]);
            acc[1] = req_valid[1] && model_ready(1);
            step_cycle();
            if (acc[1]) sent[1]++;
            if (sent[1] > 0) chk("freeze_head_stable", 32'(port_addr[1]), 32'h200);
        end
        chk("freeze_accepts", 32'(sent[1]), 32'd4);
        chk("freeze_full_ready", 32'(req_ready[1]), 32'd0);
        applyStimulus(1, 1'b0, '0, '0, 1'b0);
        freeze_inputs = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(port_valid[1]), 32'd1);
            chk("drain_order", 32'(port_addr[1]), 32'(12'h200 + i));
            step_cycle();
        end
        chk("drain_empty", 32'(port_valid[1]), 32'd0);

        // ---- Nine sequential addresses on all three clients ----
        for (int p = 0; p < 3; p++) begin
            sent[p] = 0;
            seen[p] = 0;
        end
        for (int c = 0; c < 60; c++) begin
            for (int p = 0; p < 3; p++) begin
                applyStimulus(p, sent[p] < 9, 12'(p * 256 + sent[p]), 16'(c), 1'b1);
                acc[p] = req_valid[p] && model_ready(p);
                if (port_valid[p]) begin
                    chk("seq_order", 32'(port_addr[p]), 32'(p * 256 + seen[p]));
                    seen[p]++;
                end
            end
            step_cycle();
            for (int p = 0; p < 3; p++) if (acc[p]) sent[p]++;
            if (seen[0] == 9 && seen[1] == 9 && seen[2] == 9) break;
        end
        for (int p = 0; p < 3; p++) chk("seq_all_issued", 32'(seen[p]), 32'd9);
        idle_inputs();
        step_cycle();

        // ---- Flush with three entries queued and a concurrent push ----
        freeze_inputs = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b1, 12'(12'h300 + i), 16'h5555, 1'b0);
            step_cycle();
        end
        applyStimulus(0, 1'b1, 12'h3FF, 16'h6666, 1'b1);
        flush = 1'b1;
        step_cycle();
        chk("flush_valid", 32'(port_valid[0]), 32'd0);
        chk("flush_ready", 32'(req_ready[0]), 32'd1);
        idle_inputs();
        repeat (3) begin
            step_cycle();
            chk("flush_nothing_issued", 32'(port_valid[0]), 32'd0);
        end

`ifdef TPM_FRONTEND_STATS_EN
        // ---- Counters: 3 pops and 2 stall cycles on port 3 ----
        stats_clear = 1'b1;
        step_cycle();
        stats_clear   = 1'b0;
        freeze_inputs = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2, 1'b1, 12'(12'h700 + i), 16'h1234, 1'b1);
            step_cycle();
        end
        applyStimulus(2, 1'b0, '0, '0, 1'b0);
        freeze_inputs = 1'b0;
        repeat (4) step_cycle();
        chk("stat3_issued", 32'(stat_issued[2]), 32'd3);
        chk("stat3_stall", 32'(stat_stall[2]), 32'd2);
        stats_clear = 1'b1;
        step_cycle();
        stats_clear = 1'b0;
        chk("stat3_issued_clr", 32'(stat_issued[2]), 32'd0);
        chk("stat3_stall_clr", 32'(stat_stall[2]), 32'd0);
`endif

        // ---- Randomized traffic ----
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 3; p++)
                applyStimulus(p, $urandom_range(0, 3) != 0, 12'($urandom), 16'($urandom), 1'($urandom));
            freeze_inputs = ($urandom_range(0, 2) == 0);
            flush         = ($urandom_range(0, 31) == 0);
`ifdef TPM_FRONTEND_STATS_EN
            stats_clear   = ($urandom_range(0, 63) == 0);
`endif
            step_cycle();
        end

        // ---- Asynchronous reset with queued requests ----
        idle_inputs();
        freeze_inputs = 1'b1;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 3; p++) applyStimulus(p, 1'b1, 12'(12'h400 + i), 16'hCAFE, 1'b1);
            step_cycle();
        end
        #2 reset_n = 1'b0;
        model_reset();
        #1 checkOutput();
        chk("midreset_valid2", 32'(port_valid[1]), 32'd0);
        chk("midreset_addr3", 32'(port_addr[2]), 32'd0);
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b1;
        step_cycle();
        chk("midreset_ready_back", 32'(req_ready[0]), 32'd1);
        step_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tpm_request_frontend.md
Name: tpm_request_frontend

Overview:
- Upstream stage of the triple-ported memory. Provides one request FIFO per port (3 ports).
- Accepts client requests with a valid/ready handshake.
- Presents the head entry of each FIFO on the memory's port{N}_addr/data_in/wen/valid_in inputs.
- Honours the memory's freeze_inputs back-pressure: an entry is retired only on a clock edge where the memory actually captures it.

Parameters:
- DEPTH, 4, entries per port FIFO; power of two, >= 2.
- ADDR_W, 12, request address width.
- DATA_W, 16, write data width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cN_req_valid (N=1..3)  in  1  client N request present.
- cN_req_ready (N=1..3)  out  1  FIFO N can accept a request this cycle.
- cN_addr (N=1..3)  in  ADDR_W  client N address.
- cN_data (N=1..3)  in  DATA_W  client N write data.
- cN_wen (N=1..3)  in  1  client N write enable, active high.
- portN_addr (N=1..3)  out  ADDR_W  head address to memory port N.
- portN_data_in (N=1..3)  out  DATA_W  head data to memory port N.
- portN_wen (N=1..3)  out  1  head write enable to memory port N.
- portN_valid_in (N=1..3)  out  1  head valid to memory port N.
- freeze_inputs  in  1  from memory; 1 = memory is not capturing its inputs this edge.
- flush  in  1  synchronous; empties all three FIFOs.

Behaviour:
- Reset (async, reset_n=0):
  - All FIFOs empty; read/write pointers and counts = 0.
  - cN_req_ready = 0 while reset_n is low; ready = 1 from the first cycle after release.
  - portN_valid_in = 0; portN_addr/data_in/wen = 0.
- FIFO storage: entry = {addr, data, wen}. Width = ADDR_W + DATA_W + 1. Count width = clog2(DEPTH) + 1.
- Push: occurs at a rising edge when cN_req_valid & cN_req_ready.
- Ready: cN_req_ready = ~full, derived from the registered count. No combinational path from freeze_inputs or valid to ready.
- Head outputs:
  - portN_valid_in = ~empty.
  - portN_addr/data_in/wen = the head entry, driven from registered storage.
  - When empty, they are forced to 0.
- Pop: occurs at a rising edge when portN_valid_in & ~freeze_inputs. This is the same edge on which the memory captures its inputs.
- Freeze: while freeze_inputs = 1, no pop occurs and the head outputs hold exactly stable. Pushes continue until the FIFO is full.
- Latency: a push into an empty FIFO appears on portN_* on the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Full FIFO: ready = 0. A pop in that cycle does not enable a same-cycle push; ready rises on the following cycle.
- Pointer wrap: pointers wrap modulo DEPTH. Ordering within a port is strict FIFO. Ports are independent.
- flush:
  - At the edge, pointers and counts clear and pushes/pops in that cycle are discarded.
  - Next cycle: portN_valid_in = 0 and ready = 1.
  - flush has priority over push and pop.
- Reset mid-operation: all queued requests are lost, with no partial output.

Optional Feature:
- Macro: TPM_FRONTEND_STATS_EN.
- When defined:
  - Adds outputs statN_issued (N=1..3, 16 bits): count of pops on port N, saturating at 0xFFFF.
  - Adds statN_stall (N=1..3, 16 bits): count of cycles with portN_valid_in & freeze_inputs, saturating.
  - Adds input stats_clear (1 bit): synchronous clear, with priority over increment.
  - Counters reset to 0 asynchronously.
- When undefined: these ports and all counter logic are absent. The remaining behaviour is identical.

Test Plan:
- Reset then idle → all portN_valid_in = 0 and all cN_req_ready = 1 one cycle after reset_n rises.
- c1 pushes addr 0x123 / data 0xBEEF / wen 1 with freeze = 0 → next cycle port1 shows 0x123/0xBEEF/1 with valid = 1, then valid = 0 after the pop edge.
- freeze_inputs = 1 for 6 cycles while c2 pushes 5 requests (DEPTH = 4) → c2_req_ready falls after 4 accepts and port2 outputs are stable for all 6 cycles. After freeze drops, the 4 requests issue in order on 4 consecutive edges.
- All three clients push 9 sequential addresses each with freeze = 0 → each port issues its addresses in order, and pointers wrap twice without loss.
- Flush asserted with FIFO1 holding 3 entries and a concurrent push → next cycle port1_valid_in = 0 and the pushed entry is not issued.
- With TPM_FRONTEND_STATS_EN: 3 pops on port3 and 2 freeze-stall cycles → stat3_issued = 3, stat3_stall = 2. After stats_clear, both = 0.
